// File: rtl/jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jump_ctrl
// Brief    : Jump-target generator. It selects the PC target from a writable
//            LUT or from a return-address stack.
//            The return-address stack, op_ret handling and the sticky flags
//            are built only when JUMP_CTRL_RAS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module jump_ctrl #(
    parameter int D = 10,
    parameter int L = 5,
    parameter int S = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [D-1:0]             prog_ctr,
    input  logic                     op_jump,
    input  logic                     op_branch,
    input  logic                     op_call,
    input  logic                     op_ret,
    input  logic                     cond,
    input  logic [L-1:0]             lut_idx,
    input  logic                     lut_we,
    input  logic [L-1:0]             lut_waddr,
    input  logic [D-1:0]             lut_wdata,
    output logic                     jmp_en,
    output logic [D-1:0]             absaddress,
    output logic [$clog2(S+1)-1:0]   ras_depth,
    output logic                     ras_ovf,
    output logic                     ras_unf
);

    localparam int c_DW      = $clog2(S + 1);
    localparam int c_ENTRIES = 2 ** L;

    logic [D-1:0] r_lut [c_ENTRIES];
    logic [D-1:0] w_lut_rd;
    logic         w_jmp;
    logic [D-1:0] w_addr;

    // Asynchronous read; a same-index write lands at the edge, so the old value is seen this cycle
    assign w_lut_rd = r_lut[lut_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_lut[i] <= '0;
            end
        end else if (lut_we) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

`ifdef JUMP_CTRL_RAS_EN
    logic [D-1:0]    r_ras [S];
    logic [c_DW-1:0] r_depth;
    logic            r_ovf;
    logic            r_unf;
    logic [D-1:0]    w_top;
    logic [D-1:0]    w_ret_addr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;
    logic            w_unf_set;

    assign w_ret_addr = prog_ctr + D'(1);
    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == c_DW'(S));

    // Entry depth-1 is the top of stack
    always_comb begin
        w_top = '0;
        for (int i = 0; i < S; i++) begin
            if (r_depth == c_DW'(i + 1)) begin
                w_top = r_ras[i];
            end
        end
    end

    always_comb begin
        w_jmp     = 1'b0;
        w_addr    = '0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (op_ret) begin
            if (!w_empty) begin
                w_jmp  = 1'b1;
                w_addr = w_top;
                w_pop  = 1'b1;
            end else begin
                w_unf_set = 1'b1;
            end
        end else if (op_call) begin
            w_jmp  = 1'b1;
            w_addr = w_lut_rd;
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (op_jump) begin
            w_jmp  = 1'b1;
            w_addr = w_lut_rd;
        end else if (op_branch && cond) begin
            w_jmp  = 1'b1;
            w_addr = w_lut_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < S; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            if (w_push) begin
                for (int i = 0; i < S; i++) begin
                    if (r_depth == c_DW'(i)) begin
                        r_ras[i] <= w_ret_addr;
                    end
                end
                r_depth <= r_depth + c_DW'(1);
            end else if (w_pop) begin
                r_depth <= r_depth - c_DW'(1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign ras_depth = r_depth;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;
`else
    logic w_unused;

    // Without a stack, a call is a plain jump and ret drops out of the priority chain
    always_comb begin
        w_jmp  = 1'b0;
        w_addr = '0;
        if (op_call || op_jump) begin
            w_jmp  = 1'b1;
            w_addr = w_lut_rd;
        end else if (op_branch && cond) begin
            w_jmp  = 1'b1;
            w_addr = w_lut_rd;
        end
    end

    assign w_unused  = &{1'b0, op_ret, prog_ctr};
    assign ras_depth = '0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    assign jmp_en     = w_jmp;
    assign absaddress = w_addr;

endmodule
`default_nettype wire

// File: tb/tb_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_ctrl
// Brief    : Scoreboard bench for jump_ctrl; expectations adapt to JUMP_CTRL_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_ctrl;

`ifdef JUMP_CTRL_RAS_EN
    localparam bit c_R = 1'b1;
`else
    localparam bit c_R = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [9:0] prog_ctr;
    logic       op_jump, op_branch, op_call, op_ret, cond;
    logic [4:0] lut_idx;
    logic       lut_we;
    logic [4:0] lut_waddr;
    logic [9:0] lut_wdata;
    logic       jmp_en;
    logic [9:0] absaddress;
    logic [2:0] ras_depth;
    logic       ras_ovf, ras_unf;

    typedef struct {
        string      nm;
        logic       jmp;
        logic [9:0] addr;
        logic [2:0] dep;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    jump_ctrl #(.D(10), .L(5), .S(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_ctr   (prog_ctr),
        .op_jump    (op_jump),
        .op_branch  (op_branch),
        .op_call    (op_call),
        .op_ret     (op_ret),
        .cond       (cond),
        .lut_idx    (lut_idx),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .jmp_en     (jmp_en),
        .absaddress (absaddress),
        .ras_depth  (ras_depth),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h exp=%0h", nm, fld, got, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle when an expectation is queued
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.nm, "jmp_en",     {31'b0, jmp_en},  {31'b0, e.jmp});
            cmp(e.nm, "absaddress", {22'b0, absaddress}, {22'b0, e.addr});
            cmp(e.nm, "ras_depth",  {29'b0, ras_depth},  {29'b0, e.dep});
            cmp(e.nm, "ras_ovf",    {31'b0, ras_ovf}, {31'b0, e.ovf});
            cmp(e.nm, "ras_unf",    {31'b0, ras_unf}, {31'b0, e.unf});
        end
    end

    task automatic idle();
        reset = 1'b0; prog_ctr = '0; op_jump = 0; op_branch = 0; op_call = 0; op_ret = 0;
        cond = 0; lut_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic step(input string nm, input logic j, input logic [9:0] a,
                        input logic [2:0] d, input logic o, input logic u);
        exp_t e;
        e.nm = nm; e.jmp = j; e.addr = a; e.dep = d; e.ovf = o; e.unf = u;
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [9:0] d);
        lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); @(posedge clk);
        #1;
        idle();

        step("reset", 0, 10'h000, 3'd0, 0, 0);

        wr(5'd3, 10'h155);
        step("lut_wr", 0, 10'h000, 3'd0, 0, 0);
        op_jump = 1; lut_idx = 5'd3; wr(5'd3, 10'h0AA);
        step("jmp_same_wr", 1, 10'h155, 3'd0, 0, 0);
        op_jump = 1; lut_idx = 5'd3;
        step("jmp_new_val", 1, 10'h0AA, 3'd0, 0, 0);

        wr(5'd1, 10'h020);
        step("wr1", 0, 10'h000, 3'd0, 0, 0);
        wr(5'd2, 10'h100);
        step("wr2", 0, 10'h000, 3'd0, 0, 0);
        op_branch = 1; lut_idx = 5'd1; cond = 0;
        step("br_nt", 0, 10'h000, 3'd0, 0, 0);
        op_branch = 1; lut_idx = 5'd1; cond = 1;
        step("br_t", 1, 10'h020, 3'd0, 0, 0);

        // Nested call/return
        op_call = 1; lut_idx = 5'd2; prog_ctr = 10'h010;
        step("call1", 1, 10'h100, 3'd0, 0, 0);
        op_call = 1; lut_idx = 5'd2; prog_ctr = 10'h030;
        step("call2", 1, 10'h100, c_R ? 3'd1 : 3'd0, 0, 0);
        op_ret = 1;
        step("ret1", c_R, c_R ? 10'h031 : 10'h000, c_R ? 3'd2 : 3'd0, 0, 0);
        op_ret = 1;
        step("ret2", c_R, c_R ? 10'h011 : 10'h000, c_R ? 3'd1 : 3'd0, 0, 0);
        step("nest_end", 0, 10'h000, 3'd0, 0, 0);

        // Overflow then underflow
        for (int i = 0; i < 5; i++) begin
            op_call = 1; lut_idx = 5'd2; prog_ctr = 10'h100 + 10'(i);
            step($sformatf("ovf_call%0d", i), 1, 10'h100, c_R ? 3'(i) : 3'd0, 0, 0);
        end
        step("ovf_hold", 0, 10'h000, c_R ? 3'd4 : 3'd0, c_R, 0);
        for (int i = 0; i < 4; i++) begin
            op_ret = 1;
            step($sformatf("unf_ret%0d", i), c_R, c_R ? 10'h104 - 10'(i) : 10'h000,
                 c_R ? 3'(4 - i) : 3'd0, c_R, 0);
        end
        op_ret = 1;
        step("unf_ret4", 0, 10'h000, 3'd0, c_R, 0);
        step("flags_hold", 0, 10'h000, 3'd0, c_R, c_R);

        // Priority and wrap
        op_call = 1; op_jump = 1; lut_idx = 5'd2; prog_ctr = 10'h3FF;
        step("call_jmp_wrap", 1, 10'h100, 3'd0, c_R, c_R);
        op_ret = 1; op_jump = 1; lut_idx = 5'd3;
        step("ret_over_jmp", 1, c_R ? 10'h000 : 10'h0AA, c_R ? 3'd1 : 3'd0, c_R, c_R);
        op_ret = 1; op_branch = 1; cond = 1; lut_idx = 5'd1;
        step("ret_empty_br", c_R ? 1'b0 : 1'b1, c_R ? 10'h000 : 10'h020, 3'd0, c_R, c_R);

        // Reset in the middle of activity
        for (int i = 0; i < 3; i++) begin
            op_call = 1; lut_idx = 5'd2; prog_ctr = 10'h200 + 10'(i);
            step($sformatf("pre_rst_call%0d", i), 1, 10'h100, c_R ? 3'(i) : 3'd0, c_R, c_R);
        end
        reset = 1; op_call = 1; lut_idx = 5'd2; prog_ctr = 10'h210; wr(5'd5, 10'h3FF);
        step("rst_mid_op", 1, 10'h100, c_R ? 3'd3 : 3'd0, c_R, c_R);
        step("post_rst", 0, 10'h000, 3'd0, 0, 0);
        op_jump = 1; lut_idx = 5'd5;
        step("lut_after_rst", 1, 10'h000, 3'd0, 0, 0);
        op_ret = 1;
        step("ret_after_rst", 0, 10'h000, 3'd0, 0, c_R ? 1'b0 : 1'b0);
        step("unf_after_rst", 0, 10'h000, 3'd0, 0, c_R);

        @(posedge clk); @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jump_ctrl.md
# jump_ctrl

Jump-target generator driving the `jmp_en` / `absaddress` inputs of the program counter. It decodes the control-flow fields of the current instruction and selects the next fetch address from one of two sources: a writable jump-target lookup table, or a small return-address stack (RAS). It sits between the instruction decoder and the PC, and consumes `prog_ctr` to form return addresses.

## Interface
- `D`, 10: address width; must match the PC.
- `L`, 5: LUT index width; the table holds 2^L entries of D bits.
- `S`, 4: RAS depth in entries; S ≥ 1.

- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `prog_ctr`  in  D: current PC value.
- `op_jump`  in  1: unconditional jump to `lut[lut_idx]`.
- `op_branch`  in  1: conditional jump to `lut[lut_idx]` when `cond` = 1.
- `op_call`  in  1: jump to `lut[lut_idx]` and push `prog_ctr+1`.
- `op_ret`  in  1: jump to the popped RAS top.
- `cond`  in  1: branch condition flag from the ALU.
- `lut_idx`  in  L: target-table index.
- `lut_we`  in  1: table write enable.
- `lut_waddr`  in  L: table write index.
- `lut_wdata`  in  D: table write data.
- `jmp_en`  out  1: to the PC; load `absaddress` on the next edge.
- `absaddress`  out  D: jump target; forced to 0 when `jmp_en` = 0.
- `ras_depth`  out  $clog2(S+1): number of valid RAS entries.
- `ras_ovf`  out  1: sticky overflow flag.
- `ras_unf`  out  1: sticky underflow flag.

## Operation
- Op priority when several op inputs are high: `op_ret` > `op_call` > `op_jump` > `op_branch`. Only the winning op takes effect.
- `op_jump`: `jmp_en` = 1, `absaddress` = `lut[lut_idx]`.
- `op_branch`: `jmp_en` = `cond`. When not taken, `absaddress` = 0.
- `op_call`:
  - `jmp_en` = 1, target `lut[lut_idx]`.
  - Pushes `(prog_ctr + 1) mod 2^D`; wraps, so 1023 → 0 for D = 10.
  - If `ras_depth` = S: the jump is still taken, the push is dropped, the stack is unchanged, and `ras_ovf` sets.
- `op_ret`:
  - If `ras_depth` > 0: `jmp_en` = 1, `absaddress` = top entry, entry popped.
  - If `ras_depth` = 0: `jmp_en` = 0, `absaddress` = 0, `ras_unf` sets, and the PC falls through.
- No op asserted: `jmp_en` = 0, `absaddress` = 0, no state change.
- LUT: written at the clock edge when `lut_we` = 1. The read is asynchronous on `lut_idx`.
  - Read and write of the same index in one cycle returns the old value; the new value is visible next cycle.
  - LUT writes are independent of op inputs and may coincide with any op.
- `ras_ovf` / `ras_unf` stay set until reset.
- Reset values:
  - All LUT entries 0, all RAS entries 0.
  - `ras_depth` 0, `ras_ovf` 0, `ras_unf` 0.
  - `jmp_en` and `absaddress` are combinational; they read 0 when ops are idle.

## Timing
- `jmp_en` / `absaddress` are combinational from the current-cycle op inputs and the registered state, with zero latency. The PC loads the target on the next rising edge, so there is no bubble.
- RAS push/pop, `ras_depth`, the sticky flags and LUT writes update on the rising edge of `clk`.
- Back-to-back `op_ret` is supported: each cycle sees the new top after the previous pop.
- Call immediately followed by ret returns to the call's `prog_ctr+1`.
- Reset asserted during any op has priority:
  - The stack is emptied and the flags cleared at that edge.
  - LUT writes in the reset cycle are discarded.
  - `jmp_en` still reflects the op combinationally in that cycle; the PC's own reset overrides the load.

## Configuration
- `JUMP_CTRL_RAS_EN` defined: the RAS, `op_ret` handling and the sticky flags are built as described above.
- Undefined:
  - No stack storage is built.
  - `op_call` behaves exactly as `op_jump`; no push.
  - `op_ret` is ignored: it is a no-op in the priority chain, and lower-priority ops asserted with it still act.
  - `ras_depth`, `ras_ovf` and `ras_unf` are tied to 0.

## Test plan
- LUT write/read: write `lut[3]` = 0x155. Next cycle, `op_jump`, `lut_idx` = 3 → `jmp_en` = 1, `absaddress` = 0x155. Same-cycle write of `lut[3]` = 0x0AA with the jump → still 0x155.
- Branch: `lut[1]` = 0x020; `op_branch` with `cond` = 0 → `jmp_en` = 0, `absaddress` = 0; with `cond` = 1 → `jmp_en` = 1, `absaddress` = 0x020.
- Call/return nesting: calls at `prog_ctr` = 0x010 and 0x030, then two rets → targets 0x031, then 0x011. `ras_depth` goes 1, 2, 1, 0.
- Overflow/underflow: five calls with S = 4 → the fifth jump is taken, `ras_depth` stays 4, `ras_ovf` = 1. Then five rets → the fifth gives `jmp_en` = 0 and `ras_unf` = 1. Both flags hold until reset.
- Priority and wrap: `op_call` and `op_jump` together at `prog_ctr` = 0x3FF → the call wins, pushed value is 0x000. `op_ret` and `op_jump` together with a non-empty stack → the ret target wins.
- Reset mid-operation: assert `reset` with the stack at depth 3 and `lut_we` high → the next cycle shows `ras_depth` = 0, flags 0, and the LUT entry unchanged (0). Repeat with `JUMP_CTRL_RAS_EN` undefined: call equals jump, ret is inert.
